// File: rtl/bf_pkg.sv
// bf_pkg: shared select encodings, FSM state and opcode types for the BF control FSM
package bf_pkg;
  localparam logic [1:0] ALU_SEL_PC    = 2'd0;
  localparam logic [1:0] ALU_SEL_REG   = 2'd1;
  localparam logic [1:0] ALU_SEL_DEPTH = 2'd2;
  localparam logic [1:0] ALU_SEL_TEMP  = 2'd3;
  localparam logic [1:0] DATA_SEL_MEM  = 2'd0;
  localparam logic [1:0] DATA_SEL_ALU  = 2'd1;
  localparam logic [1:0] DATA_SEL_IN   = 2'd2;
  localparam logic       ADDR_SEL_PC   = 1'b0;
  localparam logic       ADDR_SEL_REG  = 1'b1;
  localparam logic [7:0] ASCII_INC   = 8'h2B;
  localparam logic [7:0] ASCII_DEC   = 8'h2D;
  localparam logic [7:0] ASCII_RIGHT = 8'h3E;
  localparam logic [7:0] ASCII_LEFT  = 8'h3C;
  localparam logic [7:0] ASCII_OPEN  = 8'h5B;
  localparam logic [7:0] ASCII_CLOSE = 8'h5D;
  localparam logic [7:0] ASCII_OUT   = 8'h2E;
  localparam logic [7:0] ASCII_IN    = 8'h2C;
  typedef enum logic [3:0] {
    STATE_FETCH, STATE_DECODE, STATE_NEXT_PC, STATE_ALU_LOAD, STATE_ALU_OP, STATE_ALU_WB,
    STATE_SHIFT, STATE_LOOP_LOAD, STATE_LOOP_DEPTH, STATE_OUT_LOAD, STATE_OUT_WAIT,
    STATE_IN_WAIT, STATE_IN_WB, STATE_HALT, STATE_ERROR
  } state_t;
  typedef enum logic [3:0] {
    OP_INC, OP_DEC, OP_RIGHT, OP_LEFT, OP_OPEN, OP_CLOSE, OP_OUT, OP_IN, OP_NONE
  } opcode_t;
endpackage

// File: rtl/bf_instr_decoder.sv
// bf_instr_decoder: combinational BF opcode decode
//   instr     in  INSTR_W  fetched word
//   opcode    out          decoded opcode (OP_NONE for anything else)
//   not_instr out          word is not an executable opcode
//   is_eop    out          word equals the end-of-program code
module bf_instr_decoder import bf_pkg::*; #(
  parameter int                  INSTR_W  = 8,
  parameter logic [INSTR_W-1:0]  EOP_CODE = '0,
  parameter bit                  IO_EN    = 1'b1
) (
  input  logic [INSTR_W-1:0] instr,
  output opcode_t            opcode,
  output logic               not_instr,
  output logic               is_eop
);
  // ASCII codes are zero-extended, so any set upper bit rules out a match
  function automatic logic hit(input logic [INSTR_W-1:0] w, input logic [7:0] c);
    return w == INSTR_W'(c);
  endfunction
  always_comb begin
    opcode    = hit(instr, ASCII_INC)            ? OP_INC   :
                hit(instr, ASCII_DEC)            ? OP_DEC   :
                hit(instr, ASCII_RIGHT)          ? OP_RIGHT :
                hit(instr, ASCII_LEFT)           ? OP_LEFT  :
                hit(instr, ASCII_OPEN)           ? OP_OPEN  :
                hit(instr, ASCII_CLOSE)          ? OP_CLOSE :
                (IO_EN && hit(instr, ASCII_OUT)) ? OP_OUT   :
                (IO_EN && hit(instr, ASCII_IN))  ? OP_IN    : OP_NONE;
    not_instr = opcode == OP_NONE;
    is_eop    = instr == EOP_CODE;
  end
endmodule

// File: rtl/bf_control_fsm_v2.sv
// bf_control_fsm_v2: Brainfuck control FSM sequencing the PC/Reg/Depth/Temp datapath
//   clk, reset                     clock, async active-high reset
//   en                             state advance enable
//   instr                          instruction register contents
//   looping, depth_signal,         datapath status: skipping a loop body, PC direction,
//   data_is_zero, depth_at_max     temp == 0, depth saturated
//   pc_en..instr_en, write         register load enables and memory write strobe
//   operation, alu_sel, data_sel,  datapath steering
//   addr_sel
//   out_valid/out_ready            output byte handshake
//   in_ready/in_valid              input byte handshake
//   halted, error                  sticky end-of-program / loop-depth fault
module bf_control_fsm_v2 import bf_pkg::*; #(
  parameter int                 INSTR_W  = 8,
  parameter logic [INSTR_W-1:0] EOP_CODE = '0,
  parameter bit                 IO_EN    = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [INSTR_W-1:0] instr,
  input  logic               looping,
  input  logic               depth_signal,
  input  logic               data_is_zero,
  input  logic               depth_at_max,
  output logic               pc_en,
  output logic               reg_en,
  output logic               depth_en,
  output logic               temp_en,
  output logic               instr_en,
  output logic               write,
  output logic               operation,
  output logic [1:0]         alu_sel,
  output logic [1:0]         data_sel,
  output logic               addr_sel,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               in_ready,
  input  logic               in_valid,
  output logic               halted,
  output logic               error
);
  state_t  state_q, state_d, decode_target;
  opcode_t opcode;
  logic    not_instr, is_eop, is_open, is_close, is_bracket;
  logic    loop_cond, depth_ovf, depth_unf, loop_err;
  bf_instr_decoder #(.INSTR_W(INSTR_W), .EOP_CODE(EOP_CODE), .IO_EN(IO_EN)) u_dec (
    .instr     (instr),
    .opcode    (opcode),
    .not_instr (not_instr),
    .is_eop    (is_eop)
  );
  assign is_open    = opcode == OP_OPEN;
  assign is_close   = opcode == OP_CLOSE;
  assign is_bracket = is_open | is_close;
  // depth moves when skipping, when '[' skips a body, or when ']' jumps back
  assign loop_cond  = looping | (is_open & data_is_zero) | (is_close & ~data_is_zero);
  assign depth_ovf  = loop_cond & is_open & depth_at_max;
  // a ']' that starts a backward scan while already scanning back has no matching depth
  assign depth_unf  = loop_cond & is_close & ~looping & depth_signal;
  assign loop_err   = depth_ovf | depth_unf;
  always_ff @(posedge clk or posedge reset)
    if (reset) state_q <= STATE_FETCH;
    else       state_q <= state_d;
  always_comb begin
    decode_target = (opcode == OP_INC || opcode == OP_DEC)    ? STATE_ALU_LOAD :
                    (opcode == OP_RIGHT || opcode == OP_LEFT) ? STATE_SHIFT :
                    is_bracket                                ? (looping ? STATE_LOOP_DEPTH : STATE_LOOP_LOAD) :
                    (opcode == OP_OUT)                        ? STATE_OUT_LOAD : STATE_IN_WAIT;
    state_d = state_q;
    if (en)
      case (state_q)
        STATE_NEXT_PC:    state_d = STATE_FETCH;
        STATE_FETCH:      state_d = STATE_DECODE;
        STATE_DECODE:     state_d = is_eop ? STATE_HALT :
                                    (not_instr || (looping && !is_bracket)) ? STATE_NEXT_PC : decode_target;
        STATE_ALU_LOAD:   state_d = STATE_ALU_OP;
        STATE_ALU_OP:     state_d = STATE_ALU_WB;
        STATE_ALU_WB:     state_d = STATE_NEXT_PC;
        STATE_SHIFT:      state_d = STATE_NEXT_PC;
        STATE_LOOP_LOAD:  state_d = STATE_LOOP_DEPTH;
        STATE_LOOP_DEPTH: state_d = loop_err ? STATE_ERROR : STATE_NEXT_PC;
        STATE_OUT_LOAD:   state_d = STATE_OUT_WAIT;
        STATE_OUT_WAIT:   state_d = out_ready ? STATE_NEXT_PC : STATE_OUT_WAIT;
        STATE_IN_WAIT:    state_d = in_valid ? STATE_IN_WB : STATE_IN_WAIT;
        STATE_IN_WB:      state_d = STATE_NEXT_PC;
        default:          state_d = state_q;
      endcase
  end
  // outputs are forced idle while reset is held so nothing strobes during an abort
  always_comb begin
    pc_en     = 1'b0;
    reg_en    = 1'b0;
    depth_en  = 1'b0;
    temp_en   = 1'b0;
    instr_en  = 1'b0;
    write     = 1'b0;
    operation = 1'b0;
    alu_sel   = ALU_SEL_PC;
    data_sel  = DATA_SEL_MEM;
    addr_sel  = ADDR_SEL_PC;
    out_valid = 1'b0;
    in_ready  = 1'b0;
    halted    = 1'b0;
    error     = 1'b0;
    if (!reset)
      case (state_q)
        STATE_NEXT_PC:    begin pc_en = 1'b1; operation = depth_signal; end
        STATE_FETCH:      instr_en = 1'b1;
        STATE_ALU_LOAD:   begin addr_sel = ADDR_SEL_REG; temp_en = 1'b1; end
        STATE_ALU_OP:     begin alu_sel = ALU_SEL_TEMP; operation = opcode == OP_DEC; data_sel = DATA_SEL_ALU; temp_en = 1'b1; end
        STATE_ALU_WB:     begin addr_sel = ADDR_SEL_REG; write = 1'b1; end
        STATE_SHIFT:      begin alu_sel = ALU_SEL_REG; operation = opcode == OP_LEFT; reg_en = 1'b1; end
        STATE_LOOP_LOAD:  begin addr_sel = ADDR_SEL_REG; temp_en = 1'b1; end
        STATE_LOOP_DEPTH: if (loop_cond && !loop_err) begin alu_sel = ALU_SEL_DEPTH; operation = is_close; depth_en = 1'b1; end
        STATE_OUT_LOAD:   begin addr_sel = ADDR_SEL_REG; temp_en = 1'b1; end
        STATE_OUT_WAIT:   out_valid = 1'b1;
        STATE_IN_WAIT:    begin in_ready = 1'b1; data_sel = in_valid ? DATA_SEL_IN : DATA_SEL_MEM; temp_en = in_valid & en; end
        STATE_IN_WB:      begin addr_sel = ADDR_SEL_REG; write = 1'b1; end
        STATE_HALT:       halted = 1'b1;
        STATE_ERROR:      error = 1'b1;
        default:          ;
      endcase
  end
endmodule
